fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch and PC sequencing stage of the miniRISC core, directly upstream of the instruction decoder. It owns the program counter, fetches one instruction word per instruction from instruction memory through a req/ack handshake, and presents it as `ir` plus the `hlt` flag to the decoder. It consumes the decoder's PC-select (`spc`) and branch-condition (`sc`) outputs, together with the ALU flags, to compute the next PC.

## Interface
- `PC_W`, 16: PC and instruction-address width.
- `INSTR_W`, 16: instruction word width.
- `RESET_PC`, 0: PC value after reset.
- `HALT_OPC`, 6'h3F: value of `ir[5:0]` that encodes halt.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `imem_req` out 1: fetch request, held high until acknowledged.
- `imem_addr` out PC_W: fetch address; always equals the current PC.
- `imem_ack` in 1: instruction memory has returned `imem_rdata` this cycle.
- `imem_rdata` in INSTR_W: instruction word returned by memory.
- `ir` out INSTR_W: registered instruction, driven to the decoder.
- `ir_valid` out 1: high in every EXEC cycle.
- `hlt` out 1: halt indication to the decoder.
- `ex_stall` in 1: datapath holds EXEC (multi-cycle lw/sw).
- `spc` in 1: decoder selects `reg_target` as the next PC (br).
- `sc` in 3: decoder branch-condition code.
- `reg_target` in PC_W: register-sourced jump target.
- `br_off` in PC_W: sign-extended branch offset.
- `flag_z`, `flag_n`, `flag_c` in 1 each: ALU zero, negative and carry flags.
- `link_pc` out PC_W: PC+1, the return address written by bl.
- `run` in 1: resume from HALTED.
- `retired_cnt`, `taken_cnt` out 16 each: performance counters.

## Operation
- FSM states:
  - FETCH: `imem_req`=1. On `imem_ack`, capture `imem_rdata` into `ir` and go to EXEC.
  - EXEC: `ir_valid`=1. While `ex_stall`=1, hold. When `ex_stall`=0, update the PC, then go to HALTED if `ir[5:0]`==`HALT_OPC`, else to FETCH.
  - HALTED: `imem_req`=0 and `hlt`=1. On `run`=1, go to FETCH. The PC has already advanced past the halt instruction.
- `sc` decode (in the branch_cond sub-module):
  - 000: not taken.
  - 001: always taken (b, bl).
  - 010: taken if `flag_n` (bltz).
  - 011: taken if !`flag_z` (bnz).
  - 100: taken if `flag_z` (bz).
  - 101: taken if `flag_c` (bcy).
  - 110: taken if !`flag_c` (bncy).
  - 111: not taken.
- Next PC, in priority order:
  - `spc`=1: `reg_target`.
  - Else branch taken: PC+`br_off`.
  - Else: PC+1.
- All PC arithmetic is modulo 2^PC_W, so wrap-around is silent.
- `link_pc` = PC+1, combinational, and is valid throughout EXEC.
- `hlt` = (state==HALTED) | (state==EXEC & `ir[5:0]`==`HALT_OPC`). This forces the decoder to NOP controls for the halt instruction.
- `ex_stall` and `run` are ignored outside EXEC and HALTED respectively. `imem_ack` is ignored outside FETCH.

## Timing
- Reset values:
  - PC = `RESET_PC`, state = FETCH, `ir` = 0.
  - `ir_valid`, `hlt` and both counters = 0.
  - `imem_req` = 1, so the first fetch issues in the first cycle after reset deasserts.
- Reset asserted mid-fetch or mid-EXEC abandons the instruction immediately. No PC update and no counter update occur.
- Zero-wait memory (ack in the same cycle as req): 2 cycles per instruction, one FETCH plus one EXEC.
  - Each memory wait cycle adds one cycle.
  - Each `ex_stall` cycle adds one cycle.
- Flags, `spc`, `sc`, `reg_target` and `br_off` are sampled only on the final EXEC cycle, the one with `ex_stall`=0.
- `run` asserted in the same cycle the halt instruction leaves EXEC has no effect. Exit from HALTED requires `run` in HALTED.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - `retired_cnt` increments on every EXEC exit, including halt.
  - `taken_cnt` increments on every EXEC exit where `spc`=1 or the branch is taken.
  - Both counters are 16 bits and wrap.
- `FETCH_PERF_CNT_EN` undefined: both counters are removed and both outputs are tied to 0.

## Structure
- Package `fetch_pkg` holds:
  - the FSM state enum (FETCH, EXEC, HALTED);
  - the `sc` encoding constants (SC_NONE, SC_ALWAYS, SC_LTZ, SC_NZ, SC_Z, SC_CY, SC_NCY);
  - the default `HALT_OPC`.
- One sub-module, `branch_cond`: purely combinational, maps `sc` and the three flags to `taken`.

## Test plan
- Reset release, `RESET_PC`=0, zero-wait memory returning sequential non-branch words → `imem_addr` sequence 0,1,2,3; `ir_valid` high every other cycle; `retired_cnt`=3 after three instructions.
- At PC=10: `sc`=100 with `flag_z`=1 and `br_off`=0xFFFC → next `imem_addr`=6 and `taken_cnt` increments. Same instruction with `flag_z`=0 → next `imem_addr`=11.
- `spc`=1 with `reg_target`=0x0200 and `sc`=001 simultaneously → next PC=0x0200 (`spc` has priority). `link_pc` during that EXEC equals old PC+1.
- `ex_stall` high for 3 cycles on a lw at PC=4 → `ir_valid` held 4 cycles and the PC stays 4 throughout. `imem_addr`=5 only after the stall releases.
- Halt word at PC=0x0007 → `hlt`=1 from its EXEC cycle onward and `imem_req` low. `run` pulse → fetch resumes at 0x0008.
- PC=0xFFFF with a non-branch instruction → next PC=0x0000. `rst` pulsed during a wait-stated FETCH → `imem_req` restarts at `RESET_PC` and `ir_valid` stays 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch stage
package fetch_pkg;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    HALTED = 2'd2
  } state_e;

  // Branch-condition codes produced by the decoder
  localparam logic [2:0] SC_NONE   = 3'b000;
  localparam logic [2:0] SC_ALWAYS = 3'b001;
  localparam logic [2:0] SC_LTZ    = 3'b010;
  localparam logic [2:0] SC_NZ     = 3'b011;
  localparam logic [2:0] SC_Z      = 3'b100;
  localparam logic [2:0] SC_CY     = 3'b101;
  localparam logic [2:0] SC_NCY    = 3'b110;

  // Opcode field value that encodes halt
  localparam logic [5:0] HALT_OPC_DEFAULT = 6'h3F;

endpackage

// File: rtl/fetch_branch_cond.sv
// rtl/fetch_branch_cond.sv - maps branch-condition code and ALU flags to taken
module branch_cond
  import fetch_pkg::*;
(
  input  logic [2:0] sc,
  input  logic       flag_z,
  input  logic       flag_n,
  input  logic       flag_c,
  output logic       taken
);

  // Decode the condition; 000 and 111 are never taken
  always_comb begin
    taken = 1'b0;
    case (sc)
      SC_ALWAYS: taken = 1'b1;
      SC_LTZ:    taken = flag_n;
      SC_NZ:     taken = ~flag_z;
      SC_Z:      taken = flag_z;
      SC_CY:     taken = flag_c;
      SC_NCY:    taken = ~flag_c;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC sequencing and instruction fetch; FETCH_PERF_CNT_EN adds perf counters
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               PC_W     = 16,
  parameter int               INSTR_W  = 16,
  parameter logic [PC_W-1:0]  RESET_PC = '0,
  parameter logic [5:0]       HALT_OPC = HALT_OPC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  output logic               hlt,
  input  logic               ex_stall,
  input  logic               spc,
  input  logic [2:0]         sc,
  input  logic [PC_W-1:0]    reg_target,
  input  logic [PC_W-1:0]    br_off,
  input  logic               flag_z,
  input  logic               flag_n,
  input  logic               flag_c,
  output logic [PC_W-1:0]    link_pc,
  input  logic               run,
  output logic [15:0]        retired_cnt,
  output logic [15:0]        taken_cnt
);

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               br_taken;
  logic               exec_done;
  logic               is_halt;
  logic [PC_W-1:0]    next_pc;

  branch_cond u_branch_cond (
    .sc     (sc),
    .flag_z (flag_z),
    .flag_n (flag_n),
    .flag_c (flag_c),
    .taken  (br_taken)
  );

  assign is_halt   = (ir_q[5:0] == HALT_OPC);
  assign exec_done = (state_q == EXEC) && !ex_stall;
  assign link_pc   = pc_q + 1'b1;
  assign imem_addr = pc_q;
  assign ir        = ir_q;

  // Next-PC selection: register target beats taken branch beats sequential
  always_comb begin
    next_pc = pc_q + 1'b1;
    if (spc) begin
      next_pc = reg_target;
    end else if (br_taken) begin
      next_pc = pc_q + br_off;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (imem_ack) state_d = EXEC;
      EXEC:    if (!ex_stall) state_d = is_halt ? HALTED : FETCH;
      HALTED:  if (run) state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    imem_req = (state_q == FETCH);
    ir_valid = (state_q == EXEC);
    hlt      = (state_q == HALTED) || ((state_q == EXEC) && is_halt);
  end

  // PC and instruction register updates
  always_comb begin
    pc_d = pc_q;
    ir_d = ir_q;
    if ((state_q == FETCH) && imem_ack) ir_d = imem_rdata;
    if (exec_done) pc_d = next_pc;
  end

  // PC and instruction registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
      ir_q <= '0;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] retired_q, retired_d;
  logic [15:0] taken_q, taken_d;

  // Count retired instructions and redirects taken at EXEC exit
  always_comb begin
    retired_d = retired_q;
    taken_d   = taken_q;
    if (exec_done) begin
      retired_d = retired_q + 16'd1;
      if (spc || br_taken) taken_d = taken_q + 16'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= '0;
      taken_q   <= '0;
    end else begin
      retired_q <= retired_d;
      taken_q   <= taken_d;
    end
  end

  assign retired_cnt = retired_q;
  assign taken_cnt   = taken_q;
`else
  assign retired_cnt = 16'd0;
  assign taken_cnt   = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed scoreboard bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] ir;
  logic        ir_valid;
  logic        hlt;
  logic        ex_stall;
  logic        spc;
  logic [2:0]  sc;
  logic [15:0] reg_target;
  logic [15:0] br_off;
  logic        flag_z, flag_n, flag_c;
  logic [15:0] link_pc;
  logic        run;
  logic [15:0] retired_cnt;
  logic [15:0] taken_cnt;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .ir          (ir),
    .ir_valid    (ir_valid),
    .hlt         (hlt),
    .ex_stall    (ex_stall),
    .spc         (spc),
    .sc          (sc),
    .reg_target  (reg_target),
    .br_off      (br_off),
    .flag_z      (flag_z),
    .flag_n      (flag_n),
    .flag_c      (flag_c),
    .link_pc     (link_pc),
    .run         (run),
    .retired_cnt (retired_cnt),
    .taken_cnt   (taken_cnt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] pc_m;
  logic [15:0] ir_m;
  int          ret_m;
  int          tak_m;

  localparam logic [15:0] W_ALU  = 16'h1201;
  localparam logic [15:0] W_LW   = 16'h2405;
  localparam logic [15:0] W_HALT = 16'h003F;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag);
`ifdef FETCH_PERF_CNT_EN
    check({tag, "_retired"}, {16'd0, retired_cnt}, ret_m & 32'hFFFF);
    check({tag, "_taken"}, {16'd0, taken_cnt}, tak_m & 32'hFFFF);
`else
    check({tag, "_retired"}, {16'd0, retired_cnt}, 32'd0);
    check({tag, "_taken"}, {16'd0, taken_cnt}, 32'd0);
`endif
  endtask

  function automatic logic cond_taken(input logic [2:0] c, input logic z, input logic n, input logic cy);
    case (c)
      3'b001:  return 1'b1;
      3'b010:  return n;
      3'b011:  return !z;
      3'b100:  return z;
      3'b101:  return cy;
      3'b110:  return !cy;
      default: return 1'b0;
    endcase
  endfunction

  // Wait for a request, compare its address with the scoreboard, answer after waits cycles
  task automatic do_fetch(input int waits, input logic [15:0] word);
    int          n;
    logic [15:0] ea;
    n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("fetch_req", {31'd0, imem_req}, 32'd1);
    ea = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    check("fetch_addr", {16'd0, imem_addr}, {16'd0, ea});
    check("fetch_valid", {31'd0, ir_valid}, 32'd0);
    pc_m = ea;
    for (int i = 0; i < waits; i++) begin
      imem_ack = 1'b0;
      @(negedge clk);
      check("wait_req", {31'd0, imem_req}, 32'd1);
      check("wait_valid", {31'd0, ir_valid}, 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 16'($urandom);
    ir_m       = word;
    check("exec_valid", {31'd0, ir_valid}, 32'd1);
    check("exec_ir", {16'd0, ir}, {16'd0, word});
  endtask

  // Hold EXEC for stalls cycles, then retire with the given controls and push the next fetch address
  task automatic do_exec(input int stalls, input logic s_pc, input logic [2:0] s_c,
                         input logic z, input logic n, input logic cy,
                         input logic [15:0] tgt, input logic [15:0] off, input logic run_i);
    logic        tk;
    logic [15:0] nxt;
    for (int i = 0; i < stalls; i++) begin
      ex_stall = 1'b1;
      @(negedge clk);
      check("stall_valid", {31'd0, ir_valid}, 32'd1);
      check("stall_addr", {16'd0, imem_addr}, {16'd0, pc_m});
      check("stall_req", {31'd0, imem_req}, 32'd0);
    end
    ex_stall   = 1'b0;
    spc        = s_pc;
    sc         = s_c;
    flag_z     = z;
    flag_n     = n;
    flag_c     = cy;
    reg_target = tgt;
    br_off     = off;
    run        = run_i;
    check("link_pc", {16'd0, link_pc}, {16'd0, 16'(pc_m + 16'd1)});
    check("exec_hlt", {31'd0, hlt}, {31'd0, ir_m[5:0] == 6'h3F});
    tk  = cond_taken(s_c, z, n, cy);
    nxt = s_pc ? tgt : (tk ? 16'(pc_m + off) : 16'(pc_m + 16'd1));
    exp_q.push_back(nxt);
    ret_m++;
    if (s_pc || tk) tak_m++;
    @(negedge clk);
    spc        = 1'b0;
    sc         = 3'b000;
    flag_z     = 1'b0;
    flag_n     = 1'b0;
    flag_c     = 1'b0;
    reg_target = 16'($urandom);
    br_off     = 16'($urandom);
    run        = 1'b0;
    check("after_exec_addr", {16'd0, imem_addr}, {16'd0, nxt});
    check_cnt("after_exec");
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; ex_stall = 1'b0; spc = 1'b0; sc = 3'b000;
    reg_target = '0; br_off = '0; flag_z = 1'b0; flag_n = 1'b0; flag_c = 1'b0; run = 1'b0;
    ret_m = 0; tak_m = 0; pc_m = '0; ir_m = '0;
    repeat (3) @(negedge clk);
    check("rst_req", {31'd0, imem_req}, 32'd1);
    check("rst_addr", {16'd0, imem_addr}, 32'd0);
    check("rst_ir", {16'd0, ir}, 32'd0);
    check("rst_valid", {31'd0, ir_valid}, 32'd0);
    check("rst_hlt", {31'd0, hlt}, 32'd0);
    check_cnt("rst");
    rst = 1'b0;
    exp_q.push_back(16'h0000);

    // Sequential zero-wait instructions at 0,1,2
    for (int k = 0; k < 3; k++) begin
      do_fetch(0, W_ALU);
      do_exec(0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    end
    // PC=3: spc with sc=always -> register target wins over PC+5
    do_fetch(0, W_ALU);
    do_exec(0, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 16'h000A, 16'h0005, 1'b0);
    // PC=10: bz taken backwards to 6, then return and bz not taken to 11
    do_fetch(0, W_ALU);
    do_exec(0, 1'b0, 3'b100, 1'b1, 1'b0, 1'b0, 16'h0, 16'hFFFC, 1'b0);
    do_fetch(1, W_ALU);
    do_exec(0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 16'h000A, 16'h0, 1'b0);
    do_fetch(0, W_ALU);
    do_exec(0, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 16'h0, 16'hFFFC, 1'b0);
    // PC=11: spc to 0x0200 with sc=always
    do_fetch(0, W_ALU);
    do_exec(0, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 16'h0200, 16'h0040, 1'b0);
    do_fetch(0, W_ALU);
    do_exec(0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 16'h0004, 16'h0, 1'b0);
    // PC=4: wait-stated lw with three stall cycles
    do_fetch(2, W_LW);
    do_exec(3, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    do_fetch(0, W_ALU);
    do_exec(0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 16'h0007, 16'h0, 1'b0);
    // PC=7: halt, with run asserted on its final EXEC cycle (must be ignored)
    do_fetch(0, W_HALT);
    do_exec(0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("halted_hlt", {31'd0, hlt}, 32'd1);
      check("halted_req", {31'd0, imem_req}, 32'd0);
      check("halted_valid", {31'd0, ir_valid}, 32'd0);
      @(negedge clk);
    end
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    check("resume_hlt", {31'd0, hlt}, 32'd0);
    // PC=8: bltz taken, then bncy not taken
    do_fetch(0, W_ALU);
    do_exec(0, 1'b0, 3'b010, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0010, 1'b0);
    do_fetch(0, W_ALU);
    do_exec(0, 1'b0, 3'b110, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0010, 1'b0);
    // Wrap from 0xFFFF to 0 on a sequential instruction
    do_fetch(0, W_ALU);
    do_exec(0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0, 1'b0);
    do_fetch(0, W_ALU);
    do_exec(0, 1'b0, 3'b111, 1'b1, 1'b1, 1'b1, 16'h0, 16'h0008, 1'b0);
    do_fetch(0, W_ALU);
    do_exec(0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    // Reset during a wait-stated fetch at PC=1
    check("prerst_req", {31'd0, imem_req}, 32'd1);
    check("prerst_addr", {16'd0, imem_addr}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_req", {31'd0, imem_req}, 32'd1);
    check("midrst_addr", {16'd0, imem_addr}, 32'd0);
    check("midrst_valid", {31'd0, ir_valid}, 32'd0);
    ret_m = 0;
    tak_m = 0;
    check_cnt("midrst");
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_q.push_back(16'h0000);
    @(negedge clk);
    check("postrst_valid", {31'd0, ir_valid}, 32'd0);
    do_fetch(0, W_ALU);
    do_exec(0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
